// File: rtl/qos_retry_buffer.sv
// qos_retry_buffer
//   Retry buffer that keeps every issued transaction in a shared pool of
//   tagged entries until the destination acknowledges it.  A nack or a
//   timeout sends the entry back for re-issue.  Pending entries are issued
//   highest QoS class first.  An entry that runs out of retries is dropped
//   and reported.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   wr_*            new transaction in (valid/ready); wr_tag = allocated entry
//   tx_*            entry presented to egress (valid/ready), with its stored
//                   qos/des_id/payload, its tag and a re-issue flag
//   ack_*           destination response: tag, and nack (1) or ack (0)
//   drop_valid/tag  one-cycle report of an entry that exhausted its retries
//   err_ack         one-cycle pulse: response to a tag that is not in flight
//   free_cnt        number of IDLE entries (registered)
module qos_retry_buffer #(
  parameter int ENTRY_NUM     = 8,
  parameter int QOS_CLASS_NUM = 4,
  parameter int SRC_NODE_W    = 2,
  parameter int PAYLD_BW      = 8,
  parameter int TIME_OUT_CYC  = 16,
  parameter int MAX_RETRY     = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic [$clog2(QOS_CLASS_NUM)-1:0] wr_qos,
  input  logic [SRC_NODE_W-1:0]            wr_src_id,
  input  logic [PAYLD_BW-1:0]              wr_payload,
  output logic [$clog2(ENTRY_NUM)-1:0]     wr_tag,
  output logic                             tx_valid,
  input  logic                             tx_ready,
  output logic [$clog2(QOS_CLASS_NUM)-1:0] tx_qos,
  output logic [SRC_NODE_W-1:0]            tx_des_id,
  output logic [PAYLD_BW-1:0]              tx_payload,
  output logic [$clog2(ENTRY_NUM)-1:0]     tx_tag,
  output logic                             tx_retry,
  input  logic                             ack_valid,
  input  logic [$clog2(ENTRY_NUM)-1:0]     ack_tag,
  input  logic                             ack_nack,
  output logic                             drop_valid,
  output logic [$clog2(ENTRY_NUM)-1:0]     drop_tag,
  output logic                             err_ack,
  output logic [$clog2(ENTRY_NUM):0]       free_cnt
);

  localparam int TAG_W = $clog2(ENTRY_NUM);
  localparam int QOS_W = $clog2(QOS_CLASS_NUM);
  localparam int CNT_W = TAG_W + 1;
  localparam int TMR_W = $clog2(TIME_OUT_CYC);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIME_OUT_CYC - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  typedef enum logic [1:0] {
    E_IDLE,
    E_PENDING,
    E_INFLIGHT,
    E_DROP
  } entry_state_e;

  // Per-entry state and bookkeeping
  entry_state_e          st_q  [ENTRY_NUM];
  entry_state_e          st_d  [ENTRY_NUM];
  logic [RTY_W-1:0]      rty_q [ENTRY_NUM];
  logic [RTY_W-1:0]      rty_d [ENTRY_NUM];
  logic [TMR_W-1:0]      tmr_q [ENTRY_NUM];
  logic [TMR_W-1:0]      tmr_d [ENTRY_NUM];

  // Per-entry stored transaction
  logic [QOS_W-1:0]      qos_q [ENTRY_NUM];
  logic [SRC_NODE_W-1:0] des_q [ENTRY_NUM];
  logic [PAYLD_BW-1:0]   pay_q [ENTRY_NUM];

  logic [CNT_W-1:0]      free_cnt_q, free_cnt_d;
  logic                  drop_valid_q, drop_valid_d;
  logic [TAG_W-1:0]      drop_tag_q, drop_tag_d;
  logic                  err_ack_q, err_ack_d;

  // Combinational selections
  logic                  alloc_hit;
  logic [TAG_W-1:0]      alloc_tag;
  logic                  sel_vld;
  logic [TAG_W-1:0]      sel_tag;
  logic [QOS_W-1:0]      sel_qos;
  logic                  drop_any;
  logic [TAG_W-1:0]      drop_sel;

  logic                  wr_fire;
  logic                  tx_fire;
  logic                  ack_hit;
  logic                  rel_ack;

  // Lowest-index IDLE entry
  always_comb begin
    alloc_hit = 1'b0;
    alloc_tag = '0;
    for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
      if (!alloc_hit && st_q[i] == E_IDLE) begin
        alloc_hit = 1'b1;
        alloc_tag = TAG_W'(i);
      end
    end
  end

  // Highest-qos PENDING entry; strict '>' keeps the lowest index on ties
  always_comb begin
    sel_vld = 1'b0;
    sel_tag = '0;
    sel_qos = '0;
    for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
      if (st_q[i] == E_PENDING && (!sel_vld || qos_q[i] > sel_qos)) begin
        sel_vld = 1'b1;
        sel_tag = TAG_W'(i);
        sel_qos = qos_q[i];
      end
    end
  end

  // Lowest-index DROP entry, reported one per cycle
  always_comb begin
    drop_any = 1'b0;
    drop_sel = '0;
    for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
      if (!drop_any && st_q[i] == E_DROP) begin
        drop_any = 1'b1;
        drop_sel = TAG_W'(i);
      end
    end
  end

  assign wr_fire = wr_valid && wr_ready;
  assign tx_fire = sel_vld && tx_ready;
  assign ack_hit = ack_valid && (st_q[ack_tag] == E_INFLIGHT);

  // Next-state for all entries.  The four event sources (write, issue,
  // ack/timeout, drop report) each act only on entries in a distinct state,
  // so their updates never collide on the same entry.
  always_comb begin
    st_d    = st_q;
    rty_d   = rty_q;
    tmr_d   = tmr_q;
    rel_ack = 1'b0;

    for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
      if (st_q[i] == E_INFLIGHT) begin
        tmr_d[i] = tmr_q[i] + TMR_W'(1);
        if (ack_hit && ack_tag == TAG_W'(i) && !ack_nack) begin
          // ack beats a coincident timeout
          st_d[i] = E_IDLE;
          rel_ack = 1'b1;
        end else if ((ack_hit && ack_tag == TAG_W'(i)) || tmr_q[i] == TMR_LAST) begin
          // nack and timeout together are a single retry event
          if (rty_q[i] < RTY_MAX) begin
            rty_d[i] = rty_q[i] + RTY_W'(1);
            st_d[i]  = E_PENDING;
          end else begin
            st_d[i] = E_DROP;
          end
        end
      end
    end

    if (wr_fire) begin
      st_d[alloc_tag]  = E_PENDING;
      rty_d[alloc_tag] = '0;
    end

    if (tx_fire) begin
      st_d[sel_tag]  = E_INFLIGHT;
      tmr_d[sel_tag] = '0;
    end

    if (drop_any) begin
      st_d[drop_sel] = E_IDLE;
    end

    free_cnt_d   = free_cnt_q + CNT_W'(rel_ack) + CNT_W'(drop_any) - CNT_W'(wr_fire);
    drop_valid_d = drop_any;
    drop_tag_d   = drop_sel;
    err_ack_d    = ack_valid && !ack_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
        st_q[i]  <= E_IDLE;
        rty_q[i] <= '0;
        tmr_q[i] <= '0;
      end
      free_cnt_q   <= CNT_W'(ENTRY_NUM);
      drop_valid_q <= 1'b0;
      drop_tag_q   <= '0;
      err_ack_q    <= 1'b0;
    end else begin
      st_q         <= st_d;
      rty_q        <= rty_d;
      tmr_q        <= tmr_d;
      free_cnt_q   <= free_cnt_d;
      drop_valid_q <= drop_valid_d;
      drop_tag_q   <= drop_tag_d;
      err_ack_q    <= err_ack_d;
    end
  end

  // Transaction storage, written only on an accepted write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
        qos_q[i] <= '0;
        des_q[i] <= '0;
        pay_q[i] <= '0;
      end
    end else if (wr_fire) begin
      qos_q[alloc_tag] <= wr_qos;
      des_q[alloc_tag] <= wr_src_id;
      pay_q[alloc_tag] <= wr_payload;
    end
  end

  assign wr_ready   = (free_cnt_q != '0);
  assign wr_tag     = alloc_tag;

  assign tx_valid   = sel_vld;
  assign tx_tag     = sel_tag;
  assign tx_qos     = qos_q[sel_tag];
  assign tx_des_id  = des_q[sel_tag];
  assign tx_payload = pay_q[sel_tag];
  assign tx_retry   = (rty_q[sel_tag] != '0);

  assign drop_valid = drop_valid_q;
  assign drop_tag   = drop_tag_q;
  assign err_ack    = err_ack_q;
  assign free_cnt   = free_cnt_q;

endmodule

// File: tb/tb_qos_retry_buffer.sv
module tb_qos_retry_buffer;

  localparam int EN = 4;
  localparam int QN = 4;
  localparam int TO = 8;
  localparam int MR = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_qos;
  logic [1:0] wr_src_id;
  logic [7:0] wr_payload;
  logic [1:0] wr_tag;
  logic       tx_valid;
  logic       tx_ready;
  logic [1:0] tx_qos;
  logic [1:0] tx_des_id;
  logic [7:0] tx_payload;
  logic [1:0] tx_tag;
  logic       tx_retry;
  logic       ack_valid;
  logic [1:0] ack_tag;
  logic       ack_nack;
  logic       drop_valid;
  logic [1:0] drop_tag;
  logic       err_ack;
  logic [2:0] free_cnt;

  qos_retry_buffer #(
    .ENTRY_NUM    (EN),
    .QOS_CLASS_NUM(QN),
    .SRC_NODE_W   (2),
    .PAYLD_BW     (8),
    .TIME_OUT_CYC (TO),
    .MAX_RETRY    (MR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_qos    (wr_qos),
    .wr_src_id (wr_src_id),
    .wr_payload(wr_payload),
    .wr_tag    (wr_tag),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_qos    (tx_qos),
    .tx_des_id (tx_des_id),
    .tx_payload(tx_payload),
    .tx_tag    (tx_tag),
    .tx_retry  (tx_retry),
    .ack_valid (ack_valid),
    .ack_tag   (ack_tag),
    .ack_nack  (ack_nack),
    .drop_valid(drop_valid),
    .drop_tag  (drop_tag),
    .err_ack   (err_ack),
    .free_cnt  (free_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: entry lifecycle with issue timestamps; a timeout is
  // "cycle number reached issue cycle + TO", not a running timer.
  typedef enum {M_IDLE, M_PEND, M_INFL, M_DROP} mst_t;

  mst_t m_st  [EN];
  int   m_qos [EN];
  int   m_des [EN];
  int   m_pay [EN];
  int   m_rty [EN];
  int   m_iss [EN];
  bit   m_drop_v;
  int   m_drop_t;
  bit   m_err;
  int   cyc;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < EN; i++) begin
      m_st[i]  = M_IDLE;
      m_rty[i] = 0;
      m_iss[i] = 0;
    end
    m_drop_v = 1'b0;
    m_drop_t = 0;
    m_err    = 1'b0;
  endtask

  task automatic idle_in();
    wr_valid   = 1'b0;
    wr_qos     = '0;
    wr_src_id  = '0;
    wr_payload = '0;
    tx_ready   = 1'b0;
    ack_valid  = 1'b0;
    ack_tag    = '0;
    ack_nack   = 1'b0;
  endtask

  task automatic set_wr(input int q, input int s, input int p);
    wr_valid   = 1'b1;
    wr_qos     = 2'(q);
    wr_src_id  = 2'(s);
    wr_payload = 8'(p);
  endtask

  task automatic set_ack(input int t, input bit nack);
    ack_valid = 1'b1;
    ack_tag   = 2'(t);
    ack_nack  = nack;
  endtask

  // Compare every output against the model, advance the model with the
  // current inputs, then move one clock.
  task automatic step();
    int   e_free, e_wtag, e_ttag, best, n_dt;
    bit   e_tv, wr_fire, tx_fire, ack_hit, n_dv, own, tmo;
    mst_t ns [EN];

    e_free = 0;
    e_wtag = -1;
    for (int i = 0; i < EN; i++) begin
      if (m_st[i] == M_IDLE) begin
        e_free++;
        if (e_wtag < 0) e_wtag = i;
      end
    end
    best = -1;
    for (int i = 0; i < EN; i++)
      if (m_st[i] == M_PEND && m_qos[i] > best) best = m_qos[i];
    e_tv   = (best >= 0);
    e_ttag = -1;
    for (int i = 0; i < EN; i++)
      if (e_ttag < 0 && m_st[i] == M_PEND && m_qos[i] == best) e_ttag = i;

    chk("free_cnt", 32'(free_cnt), 32'(e_free));
    chk("wr_ready", 32'(wr_ready), 32'(e_free != 0));
    if (e_free != 0) chk("wr_tag", 32'(wr_tag), 32'(e_wtag));
    chk("tx_valid", 32'(tx_valid), 32'(e_tv));
    if (e_tv) begin
      chk("tx_tag",     32'(tx_tag),     32'(e_ttag));
      chk("tx_qos",     32'(tx_qos),     32'(m_qos[e_ttag]));
      chk("tx_des_id",  32'(tx_des_id),  32'(m_des[e_ttag]));
      chk("tx_payload", 32'(tx_payload), 32'(m_pay[e_ttag]));
      chk("tx_retry",   32'(tx_retry),   32'(m_rty[e_ttag] != 0));
    end
    chk("drop_valid", 32'(drop_valid), 32'(m_drop_v));
    if (m_drop_v) chk("drop_tag", 32'(drop_tag), 32'(m_drop_t));
    chk("err_ack", 32'(err_ack), 32'(m_err));

    if (rst) begin
      model_reset();
    end else begin
      wr_fire = wr_valid && (e_free != 0);
      tx_fire = e_tv && tx_ready;
      ack_hit = ack_valid && (m_st[ack_tag] == M_INFL);
      n_dv = 1'b0;
      n_dt = 0;
      for (int i = 0; i < EN; i++) begin
        if (!n_dv && m_st[i] == M_DROP) begin
          n_dv = 1'b1;
          n_dt = i;
        end
      end
      ns = m_st;
      for (int i = 0; i < EN; i++) begin
        if (m_st[i] == M_INFL) begin
          own = ack_hit && (int'(ack_tag) == i);
          tmo = (cyc - m_iss[i]) == TO;
          if (own && !ack_nack) ns[i] = M_IDLE;
          else if (own || tmo) begin
            if (m_rty[i] < MR) begin
              m_rty[i]++;
              ns[i] = M_PEND;
            end else begin
              ns[i] = M_DROP;
            end
          end
        end
      end
      if (n_dv) ns[n_dt] = M_IDLE;
      if (wr_fire) begin
        ns[e_wtag]    = M_PEND;
        m_rty[e_wtag] = 0;
        m_qos[e_wtag] = int'(wr_qos);
        m_des[e_wtag] = int'(wr_src_id);
        m_pay[e_wtag] = int'(wr_payload);
      end
      if (tx_fire) begin
        ns[e_ttag]    = M_INFL;
        m_iss[e_ttag] = cyc;
      end
      m_err    = ack_valid && !ack_hit;
      m_drop_v = n_dv;
      m_drop_t = n_dt;
      m_st     = ns;
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    cyc = 0;
    idle_in();
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_free_cnt", 32'(free_cnt), 32'd4);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_drop_valid", 32'(drop_valid), 32'd0);
    chk("rst_err_ack", 32'(err_ack), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);

    // Single write, issue, ack
    set_wr(1, 2, 8'hA5);
    tx_ready = 1'b1;
    step();
    wr_valid = 1'b0;
    chk("t1_tx_valid", 32'(tx_valid), 32'd1);
    chk("t1_tx_tag", 32'(tx_tag), 32'd0);
    chk("t1_tx_retry", 32'(tx_retry), 32'd0);
    chk("t1_tx_payload", 32'(tx_payload), 32'hA5);
    step();
    idle_in();
    set_ack(0, 1'b0);
    step();
    idle_in();
    chk("t1_free_cnt", 32'(free_cnt), 32'd4);
    step();

    // QoS ordering: tag1, tag2, tag0
    set_wr(0, 1, 8'h10); step();
    set_wr(3, 2, 8'h11); step();
    set_wr(3, 3, 8'h12); step();
    idle_in();
    tx_ready = 1'b1;
    chk("t2_order0", 32'(tx_tag), 32'd1); step();
    chk("t2_order1", 32'(tx_tag), 32'd2); step();
    chk("t2_order2", 32'(tx_tag), 32'd0); step();
    idle_in();
    set_ack(1, 1'b0); step();
    set_ack(2, 1'b0); step();
    set_ack(0, 1'b0); step();
    idle_in();
    step();

    // Full pool
    for (int i = 0; i < EN; i++) begin
      set_wr(i, i, 8'h20 + i);
      step();
    end
    idle_in();
    chk("t3_wr_ready", 32'(wr_ready), 32'd0);
    chk("t3_free_cnt", 32'(free_cnt), 32'd0);
    set_wr(2, 1, 8'h99);
    step();
    idle_in();
    chk("t3_free_hold", 32'(free_cnt), 32'd0);
    tx_ready = 1'b1;
    repeat (EN) step();
    idle_in();
    for (int i = 0; i < EN; i++) begin
      set_ack(i, 1'b0);
      step();
    end
    idle_in();
    step();

    // Timeouts until drop
    set_wr(2, 1, 8'h5A);
    step();
    idle_in();
    for (int r = 0; r < MR; r++) begin
      tx_ready = 1'b1;
      step();
      idle_in();
      repeat (TO - 1) step();
      chk("t4_not_yet", 32'(tx_valid), 32'd0);
      step();
      chk("t4_repend", 32'(tx_valid), 32'd1);
      chk("t4_retry", 32'(tx_retry), 32'd1);
    end
    tx_ready = 1'b1;
    step();
    idle_in();
    repeat (TO) step();
    chk("t4_drop_early", 32'(drop_valid), 32'd0);
    step();
    chk("t4_drop_valid", 32'(drop_valid), 32'd1);
    chk("t4_drop_tag", 32'(drop_tag), 32'd0);
    chk("t4_free_cnt", 32'(free_cnt), 32'd4);
    step();
    chk("t4_drop_pulse", 32'(drop_valid), 32'd0);

    // Ack coinciding with timeout
    set_wr(1, 0, 8'h33);
    step();
    idle_in();
    tx_ready = 1'b1;
    step();
    idle_in();
    repeat (TO - 1) step();
    set_ack(0, 1'b0);
    step();
    idle_in();
    chk("t5_ack_free", 32'(free_cnt), 32'd4);
    chk("t5_ack_no_tx", 32'(tx_valid), 32'd0);
    repeat (3) step();
    chk("t5_ack_no_drop", 32'(drop_valid), 32'd0);

    // Nack coinciding with timeout: one retry only
    set_wr(1, 0, 8'h44);
    step();
    idle_in();
    tx_ready = 1'b1;
    step();
    idle_in();
    repeat (TO - 1) step();
    set_ack(0, 1'b1);
    step();
    idle_in();
    chk("t5_nack_tx", 32'(tx_valid), 32'd1);
    chk("t5_nack_retry", 32'(tx_retry), 32'd1);
    tx_ready = 1'b1;
    step();
    idle_in();
    repeat (TO) step();
    chk("t5_nack_repend", 32'(tx_valid), 32'd1);
    chk("t5_nack_no_drop", 32'(drop_valid), 32'd0);
    tx_ready = 1'b1;
    step();
    idle_in();
    set_ack(0, 1'b0);
    step();
    idle_in();
    step();

    // Ack to an IDLE tag
    set_ack(3, 1'b0);
    step();
    idle_in();
    chk("t6_err_ack", 32'(err_ack), 32'd1);
    chk("t6_free_cnt", 32'(free_cnt), 32'd4);
    step();
    chk("t6_err_pulse", 32'(err_ack), 32'd0);

    // Reset with three in flight
    tx_ready = 1'b1;
    set_wr(1, 1, 8'h61); step();
    set_wr(2, 2, 8'h62); step();
    set_wr(3, 3, 8'h63); step();
    wr_valid = 1'b0;
    step();
    idle_in();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t7_free_cnt", 32'(free_cnt), 32'd4);
    chk("t7_tx_valid", 32'(tx_valid), 32'd0);
    chk("t7_drop_valid", 32'(drop_valid), 32'd0);
    repeat (2 * TO) step();

    // Randomized traffic against the model
    repeat (600) begin
      rst        = ($urandom_range(0, 199) == 0);
      wr_valid   = ($urandom_range(0, 1) == 1);
      wr_qos     = 2'($urandom_range(0, QN - 1));
      wr_src_id  = 2'($urandom);
      wr_payload = 8'($urandom);
      tx_ready   = ($urandom_range(0, 9) < 6);
      ack_valid  = ($urandom_range(0, 9) < 4);
      ack_tag    = 2'($urandom_range(0, EN - 1));
      ack_nack   = ($urandom_range(0, 9) < 3);
      step();
    end
    idle_in();
    rst = 1'b0;
    repeat (4 * TO) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
